// File: rtl/instr_encoder_loader_if.sv
// Loader bus: field-level instruction requests in, encoded instruction-memory writes out.
// master drives requests and imem_ready; slave is the loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] word_count;

  modport master (
    output start, base_addr, in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
           in_shamt, in_funct, in_imm, in_target, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, word_count
  );

  modport slave (
    input  start, base_addr, in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
           in_shamt, in_funct, in_imm, in_target, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, word_count
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// MIPS program loader: encodes field requests into words and streams them to imem; accept-to-write 2 cycles, 1 word/cycle.
// Backpressure: imem_ready=0 holds the write register and fills the FIFO; in_ready drops when the FIFO is full.
module fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_encoder_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_LW   = 3'd1;
  localparam logic [2:0] K_SW   = 3'd2;
  localparam logic [2:0] K_BNE  = 3'd3;
  localparam logic [2:0] K_XORI = 3'd4;
  localparam logic [2:0] K_J    = 3'd5;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              legal;
  logic              push;
  logic              pop;
  logic              wr_fire;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       enc_word;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W-1:0] ptr_eff;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_o;
  logic              done_o;

  assign bus.in_ready = (state == LOAD) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = (bus.in_kind <= K_J);
  assign push         = accept && legal;
  assign wr_fire      = we_q && bus.imem_ready;
  assign pop          = !fifo_empty && (!we_q || bus.imem_ready);
  // A word popped in the same cycle as a write handshake lands on the following address.
  assign ptr_eff      = wr_fire ? addr_ptr + WORD_STEP : addr_ptr;

  always_comb begin
    enc_word = '0;
    case (bus.in_kind)
      K_R:     enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      K_LW:    enc_word = {OP_LW,   bus.in_rs, bus.in_rt, bus.in_imm};
      K_SW:    enc_word = {OP_SW,   bus.in_rs, bus.in_rt, bus.in_imm};
      K_BNE:   enc_word = {OP_BNE,  bus.in_rs, bus.in_rt, bus.in_imm};
      K_XORI:  enc_word = {OP_XORI, bus.in_rs, bus.in_rt, bus.in_imm};
      K_J:     enc_word = {OP_J, bus.in_target};
      default: enc_word = '0;
    endcase
  end

  fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (accept && bus.in_last) state_nxt = FLUSH;
      FLUSH:   if (fifo_empty && (!we_q || bus.imem_ready)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (state == IDLE && bus.start) begin
      addr_ptr <= bus.base_addr & ~ADDR_W'(3);
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_fire) begin
        addr_ptr <= addr_ptr + WORD_STEP;
        cnt_q    <= cnt_q + CNT_ONE;
      end
      if (accept && !legal) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (pop) begin
      we_q    <= 1'b1;
      addr_q  <= ptr_eff;
      wdata_q <= head;
    end else if (wr_fire) begin
      we_q    <= 1'b0;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.err        = err_q;
  assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: inputs driven 1ns after rising edges, outputs sampled on falling edges.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam logic [2:0] K_R = 3'd0, K_LW = 3'd1, K_SW = 3'd2, K_BNE = 3'd3, K_XORI = 3'd4, K_J = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic [ADDR_W-1:0] cap_addr [$];
  logic [31:0]       cap_data [$];
  int                cap_edge [$];

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) iface ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (iface)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write handshakes and done pulses seen here complete at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && iface.imem_we && iface.imem_ready) begin
      cap_addr.push_back(iface.imem_addr);
      cap_data.push_back(iface.imem_wdata);
      cap_edge.push_back(cyc + 1);
    end
    if (iface.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] base);
    iface.base_addr = base;
    iface.start = 1'b1;
    @(posedge clk); #1;
    iface.start = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                         input logic [15:0] imm, input logic [25:0] target, input logic last);
    iface.in_kind = kind;   iface.in_rs = rs;       iface.in_rt = rt;
    iface.in_rd = rd;       iface.in_shamt = shamt; iface.in_funct = funct;
    iface.in_imm = imm;     iface.in_target = target; iface.in_last = last;
  endtask

  task automatic send(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                      input logic [15:0] imm, input logic [25:0] target, input logic last);
    logic rdy;
    int   n;
    set_req(kind, rs, rt, rd, shamt, funct, imm, target, last);
    iface.in_valid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = iface.in_ready;
      @(posedge clk); #1;
      n++;
    end
    iface.in_valid = 1'b0;
    iface.in_last = 1'b0;
    n_checks++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL send_accept: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = iface.done;
      n++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({iface.in_ready, iface.imem_we, iface.busy, iface.done, iface.err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready/we/busy/done/err=%b, required 00000",
               {iface.in_ready, iface.imem_we, iface.busy, iface.done, iface.err});
    end
    n_checks++;
    if (iface.imem_addr !== '0 || iface.imem_wdata !== 32'h0 || iface.word_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h wdata=%h count=%0d, required 0/0/0",
               iface.imem_addr, iface.imem_wdata, iface.word_count);
    end
  endtask

  task automatic test_basic();
    int c0 = cap_addr.size();
    int d0 = done_cnt;
    logic [ADDR_W-1:0] ea [2];
    logic [31:0]       ed [2];
    ea[0] = 10'h040; ed[0] = 32'h012A4020;
    ea[1] = 10'h044; ed[1] = 32'h8FA80004;
    iface.imem_ready = 1'b1;
    do_start(10'h040);
    n_checks++;
    if (iface.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", iface.busy); end
    send(K_R, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    n_checks++;
    if (iface.imem_we !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: imem_we=%b, required 0", iface.imem_we); end
    @(posedge clk); #1;
    n_checks++;
    if (iface.imem_we !== 1'b1 || iface.imem_addr !== 10'h040 || iface.imem_wdata !== 32'h012A4020) begin
      n_fail++;
      $display("FAIL basic_latency: we=%b addr=%h data=%h, required 1/040/012a4020",
               iface.imem_we, iface.imem_addr, iface.imem_wdata);
    end
    send(K_LW, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1);
    wait_done();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (cap_addr.size() - c0 != 2) begin n_fail++; $display("FAIL basic_nwrites: got %0d, required 2", cap_addr.size() - c0); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (c0 + i >= cap_addr.size() || cap_addr[c0+i] !== ea[i] || cap_data[c0+i] !== ed[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: missing or wrong, required addr %h data %h", i, ea[i], ed[i]);
      end
    end
    n_checks++;
    if (iface.word_count !== 10'd2 || iface.err !== 1'b0 || iface.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: count=%0d err=%b busy=%b, required 2/0/0", iface.word_count, iface.err, iface.busy);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || cap_edge.size() == 0 || done_cyc != cap_edge[cap_edge.size()-1]) begin
      n_fail++;
      $display("FAIL basic_done_pulse: pulses=%0d at cycle %0d, required 1 pulse right after last write", done_cnt - d0, done_cyc);
    end
  endtask

  task automatic test_encode();
    int c0 = cap_addr.size();
    logic [ADDR_W-1:0] ea [4];
    logic [31:0]       ed [4];
    ea[0] = 10'h100; ed[0] = 32'hAFA80008;
    ea[1] = 10'h104; ed[1] = 32'h1509FFFE;
    ea[2] = 10'h108; ed[2] = 32'h3909FFFF;
    ea[3] = 10'h10C; ed[3] = 32'h08100000;
    iface.imem_ready = 1'b1;
    do_start(10'h100);
    send(K_SW,   5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0);
    send(K_BNE,  5'd8,  5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0, 1'b0);
    send(K_XORI, 5'd8,  5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
    send(K_J,    5'd0,  5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b1);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (c0 + i >= cap_addr.size() || cap_addr[c0+i] !== ea[i] || cap_data[c0+i] !== ed[i]) begin
        n_fail++;
        $display("FAIL encode_write%0d: missing or wrong, required addr %h data %h", i, ea[i], ed[i]);
      end
    end
    n_checks++;
    if (cap_edge.size() < c0 + 4 || cap_edge[c0+3] - cap_edge[c0] != 3) begin
      n_fail++;
      $display("FAIL encode_throughput: 4 writes not on consecutive cycles (captured %0d)", cap_addr.size() - c0);
    end
    n_checks++;
    if (iface.word_count !== 10'd4) begin n_fail++; $display("FAIL encode_count: got %0d, required 4", iface.word_count); end
  endtask

  task automatic test_backpressure();
    int c0 = cap_addr.size();
    int accepts = 0;
    int n = 0;
    logic rdy;
    logic [31:0] ed [6];
    ed[0] = 32'h00220821; ed[1] = 32'h00221021; ed[2] = 32'h00221821;
    ed[3] = 32'h00222021; ed[4] = 32'h00222821; ed[5] = 32'h00223021;
    iface.imem_ready = 1'b0;
    do_start(10'h200);
    set_req(K_R, 5'd1, 5'd2, 5'd1, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
    iface.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = iface.in_ready;
      if (iface.imem_we) begin
        n_checks++;
        if (iface.imem_addr !== 10'h200 || iface.imem_wdata !== 32'h00220821) begin
          n_fail++;
          $display("FAIL bp_stable: addr=%h data=%h, required 200/00220821", iface.imem_addr, iface.imem_wdata);
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        accepts++;
        iface.in_rd = 5'(accepts + 1);
        iface.in_last = (accepts == 5);
      end
    end
    n_checks++;
    if (accepts != DEPTH + 1 || iface.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accepts: accepts=%0d in_ready=%b, required %0d/0", accepts, iface.in_ready, DEPTH + 1);
    end
    iface.imem_ready = 1'b1;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = iface.in_ready;
      @(posedge clk); #1;
      n++;
    end
    iface.in_valid = 1'b0;
    iface.in_last = 1'b0;
    n_checks++;
    if (!rdy) begin n_fail++; $display("FAIL bp_release: in_ready stayed 0, required 1"); end
    wait_done();
    n_checks++;
    if (cap_addr.size() - c0 != 6) begin n_fail++; $display("FAIL bp_nwrites: got %0d, required 6", cap_addr.size() - c0); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (c0 + i >= cap_addr.size() || cap_addr[c0+i] !== 10'(10'h200 + 4 * i) || cap_data[c0+i] !== ed[i]) begin
        n_fail++;
        $display("FAIL bp_write%0d: missing or wrong, required addr %h data %h", i, 10'(10'h200 + 4 * i), ed[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int c0 = cap_addr.size();
    iface.imem_ready = 1'b1;
    do_start(10'h080);
    send(K_R,  5'd1,  5'd2, 5'd1, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
    send(3'd7, 5'd0,  5'd0, 5'd0, 5'd0, 6'h0,  16'h0, 26'h0, 1'b0);
    send(K_LW, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0,  16'h0004, 26'h0, 1'b1);
    wait_done();
    n_checks++;
    if (cap_addr.size() - c0 != 2 || iface.err !== 1'b1 || iface.word_count !== 10'd2) begin
      n_fail++;
      $display("FAIL illegal_status: writes=%0d err=%b count=%0d, required 2/1/2", cap_addr.size() - c0, iface.err, iface.word_count);
    end
    n_checks++;
    if (cap_addr.size() < c0 + 2 || cap_addr[c0] !== 10'h080 || cap_data[c0] !== 32'h00220821 ||
        cap_addr[c0+1] !== 10'h084 || cap_data[c0+1] !== 32'h8FA80004) begin
      n_fail++;
      $display("FAIL illegal_writes: required 00220821@080 then 8fa80004@084");
    end
    c0 = cap_addr.size();
    do_start(10'h0C0);
    n_checks++;
    if (iface.err !== 1'b0 || iface.word_count !== 10'd0) begin
      n_fail++;
      $display("FAIL illegal_clear: err=%b count=%0d, required 0/0", iface.err, iface.word_count);
    end
    send(K_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b1);
    wait_done();
    n_checks++;
    if (cap_addr.size() != c0 + 1 || cap_addr[c0] !== 10'h0C0 || cap_data[c0] !== 32'h08000000 || iface.err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_next_load: writes=%0d err=%b, required 1 write 08000000@0c0 and err 0", cap_addr.size() - c0, iface.err);
    end
  endtask

  task automatic test_zero_word();
    int c0 = cap_addr.size();
    int d0 = done_cnt;
    iface.imem_ready = 1'b1;
    do_start(10'h000);
    send(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b1);
    wait_done();
    n_checks++;
    if (cap_addr.size() != c0 || iface.word_count !== 10'd0 || iface.err !== 1'b1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_word: writes=%0d count=%0d err=%b done=%0d, required 0/0/1/1",
               cap_addr.size() - c0, iface.word_count, iface.err, done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    int c0 = cap_addr.size();
    iface.imem_ready = 1'b1;
    do_start(10'h3FF);
    send(K_XORI, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0);
    send(K_J,    5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 1'b1);
    wait_done();
    n_checks++;
    if (cap_addr.size() != c0 + 2 || cap_addr[c0] !== 10'h3FC || cap_data[c0] !== 32'h38221234 ||
        cap_addr[c0+1] !== 10'h000 || cap_data[c0+1] !== 32'h0BFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_writes: writes=%0d, required 38221234@3fc then 0bffffff@000", cap_addr.size() - c0);
    end
    n_checks++;
    if (iface.word_count !== 10'd2) begin n_fail++; $display("FAIL wrap_count: got %0d, required 2", iface.word_count); end
  endtask

  task automatic test_reset_flush();
    int c0;
    iface.imem_ready = 1'b0;
    do_start(10'h000);
    send(K_R, 5'd1, 5'd2, 5'd1, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
    send(K_R, 5'd1, 5'd2, 5'd2, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
    send(K_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b1);
    n_checks++;
    if (iface.busy !== 1'b1 || iface.imem_we !== 1'b1 || iface.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rflush_pre: busy=%b we=%b ready=%b, required 1/1/0", iface.busy, iface.imem_we, iface.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({iface.in_ready, iface.imem_we, iface.busy, iface.done, iface.err} !== 5'b0 ||
        iface.imem_addr !== '0 || iface.imem_wdata !== 32'h0 || iface.word_count !== '0) begin
      n_fail++;
      $display("FAIL rflush_async: flags=%b addr=%h data=%h count=%0d, required all 0",
               {iface.in_ready, iface.imem_we, iface.busy, iface.done, iface.err},
               iface.imem_addr, iface.imem_wdata, iface.word_count);
    end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    iface.imem_ready = 1'b1;
    c0 = cap_addr.size();
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (cap_addr.size() != c0 || iface.imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rflush_no_write: writes=%0d we=%b, required 0/0", cap_addr.size() - c0, iface.imem_we);
    end
    do_start(10'h010);
    send(K_R, 5'd1, 5'd2, 5'd4, 5'd0, 6'h21, 16'h0, 26'h0, 1'b1);
    wait_done();
    n_checks++;
    if (cap_addr.size() != c0 + 1 || cap_addr[c0] !== 10'h010 || cap_data[c0] !== 32'h00222021 || iface.word_count !== 10'd1) begin
      n_fail++;
      $display("FAIL rflush_reload: writes=%0d count=%0d, required 1 write 00222021@010 and count 1",
               cap_addr.size() - c0, iface.word_count);
    end
  endtask

  initial begin
    iface.start = 1'b0;
    iface.base_addr = '0;
    iface.in_valid = 1'b0;
    iface.imem_ready = 1'b0;
    set_req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    repeat (2) @(posedge clk); #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_encode();
    test_backpressure();
    test_illegal();
    test_zero_word();
    test_wrap();
    test_reset_flush();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
